// File: rtl/fft_pkg.sv
// fft_pkg: shared FFT constants, output sequencer state type and address bit reversal.
package fft_pkg;
  localparam int FFT_ADDR_W = 8;
  localparam int FFT_DATA_W = 32;
  localparam int FFT_MAX_W  = 16;
  typedef enum logic [1:0] {IDLE, RUN, DRAIN} seq_state_t;
  // Reverses the low w bits of a; bits at and above w come back as zero.
  function automatic logic [FFT_MAX_W-1:0] bitrev(input logic [FFT_MAX_W-1:0] a, input int w);
    logic [FFT_MAX_W-1:0] r;
    r = '0;
    for (int i = 0; i < w; i++) r[i] = a[w-1-i];
    return r;
  endfunction
endpackage

// File: rtl/out_skid2.sv
// out_skid2: 2-entry FIFO carrying data+last, with a registered head driving the output stream.
module out_skid2 #(
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              i_push,
  input  logic [DATA_W-1:0] i_data,
  input  logic              i_last,
  input  logic              i_pop,
  output logic              o_valid,
  output logic [DATA_W-1:0] o_data,
  output logic              o_last,
  output logic [1:0]        o_count
);
  logic [1:0]        r_cnt;
  logic [DATA_W-1:0] r_d0, r_d1;
  logic              r_l0, r_l1;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt <= '0;
      r_d0  <= '0;
      r_l0  <= 1'b0;
      r_d1  <= '0;
      r_l1  <= 1'b0;
    end else begin
      r_cnt <= r_cnt + {1'b0, i_push} - {1'b0, i_pop};
      if (i_pop) begin
        r_d0 <= (r_cnt == 2'd2) ? r_d1 : i_data;
        r_l0 <= (r_cnt == 2'd2) ? r_l1 : i_last;
      end else if (i_push && r_cnt == 2'd0) begin
        r_d0 <= i_data;
        r_l0 <= i_last;
      end
      // Second slot fills only when the head is occupied and stays so.
      if (i_push && (r_cnt == 2'd2 || (r_cnt == 2'd1 && !i_pop))) begin
        r_d1 <= i_data;
        r_l1 <= i_last;
      end
    end
  end
  assign o_valid = r_cnt != 2'd0;
  assign o_data  = r_d0;
  assign o_last  = r_l0;
  assign o_count = r_cnt;
endmodule

// File: rtl/fft_out_sequencer.sv
// fft_out_sequencer: reads the FFT result RAM (natural or bit-reversed order) and streams
// samples on valid/ready, flagging the final sample with out_last and pulsing done.
module fft_out_sequencer import fft_pkg::*; #(
  parameter int ADDR_W  = FFT_ADDR_W,
  parameter int DATA_W  = FFT_DATA_W,
  parameter bit BIT_REV = 1'b1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [ADDR_W-1:0] num_m1,
  output logic              rd_en,
  output logic [ADDR_W-1:0] rd_addr,
  input  logic [DATA_W-1:0] rd_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic              out_last,
  output logic              busy,
  output logic              done
);
  seq_state_t        r_state, w_next;
  logic [ADDR_W-1:0] r_num, r_cnt;
  logic              r_infl, r_infl_last, r_done;
  logic [1:0]        w_count;
  logic              w_pop, w_hit, w_credit, w_accept;
  assign w_pop    = out_valid & out_ready;
  assign w_hit    = r_cnt == r_num;
  assign w_accept = (r_state == IDLE) && start;
  // Buffer slots plus the read in flight must stay within the two buffer entries.
  assign w_credit = ({1'b0, w_count} + {2'b0, r_infl}) < (3'd2 + {2'b0, w_pop});
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= IDLE;
    else r_state <= w_next;
  end
  always_comb begin
    w_next = r_state;
    w_next = w_accept ? RUN :
             (r_state == RUN && rd_en && w_hit) ? DRAIN :
             (r_state == DRAIN && w_pop && out_last) ? IDLE : r_state;
  end
  always_comb begin
    rd_en   = (r_state == RUN) && w_credit;
    busy    = r_state != IDLE;
    rd_addr = BIT_REV ? ADDR_W'(bitrev(FFT_MAX_W'(r_cnt), ADDR_W)) : r_cnt;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_num       <= '0;
      r_cnt       <= '0;
      r_infl      <= 1'b0;
      r_infl_last <= 1'b0;
      r_done      <= 1'b0;
    end else begin
      if (w_accept) begin
        r_num <= num_m1;
        r_cnt <= '0;
      end else if (rd_en && !w_hit) begin
        r_cnt <= r_cnt + 1'b1;
      end
      r_infl      <= rd_en;
      r_infl_last <= rd_en && w_hit;
      r_done      <= w_pop && out_last;
    end
  end
  assign done = r_done;
  out_skid2 #(.DATA_W(DATA_W)) u_skid (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_push  (r_infl),
    .i_data  (rd_data),
    .i_last  (r_infl_last),
    .i_pop   (w_pop),
    .o_valid (out_valid),
    .o_data  (out_data),
    .o_last  (out_last),
    .o_count (w_count)
  );
endmodule

// File: tb/tb_fft_out_sequencer.sv
// tb_fft_out_sequencer: drives a natural-order and a bit-reversed sequencer in lockstep
// from a table of frames, checking every read, handshake and status bit against a model.
module tb_fft_out_sequencer;
  logic        clk = 1'b0, rst_n = 1'b0, start = 1'b0, out_ready = 1'b0;
  logic [7:0]  num_m1 = '0;
  logic        rd_en[2], out_valid[2], out_last[2], busy[2], done[2];
  logic [7:0]  rd_addr[2];
  logic [31:0] rd_data[2], out_data[2];

  always #5 clk = ~clk;

  fft_out_sequencer #(.BIT_REV(1'b0)) u_nat (
    .clk(clk), .rst_n(rst_n), .start(start), .num_m1(num_m1),
    .rd_en(rd_en[0]), .rd_addr(rd_addr[0]), .rd_data(rd_data[0]),
    .out_valid(out_valid[0]), .out_ready(out_ready), .out_data(out_data[0]),
    .out_last(out_last[0]), .busy(busy[0]), .done(done[0]));
  fft_out_sequencer #(.BIT_REV(1'b1)) u_rev (
    .clk(clk), .rst_n(rst_n), .start(start), .num_m1(num_m1),
    .rd_en(rd_en[1]), .rd_addr(rd_addr[1]), .rd_data(rd_data[1]),
    .out_valid(out_valid[1]), .out_ready(out_ready), .out_data(out_data[1]),
    .out_last(out_last[1]), .busy(busy[1]), .done(done[1]));

  function automatic logic [7:0] rev8(input logic [7:0] a);
    logic [7:0] r;
    for (int i = 0; i < 8; i++) r[i] = a[7-i];
    return r;
  endfunction
  function automatic logic [31:0] ram_val(input logic [7:0] a);
    return {a, 8'h3C, ~a, 8'hC3};
  endfunction
  function automatic logic [7:0] map_addr(input int d, input int i);
    logic [7:0] a;
    a = 8'(i);
    return (d == 1) ? rev8(a) : a;
  endfunction

  always @(posedge clk) begin
    if (rd_en[0]) rd_data[0] <= ram_val(rd_addr[0]);
    if (rd_en[1]) rd_data[1] <= ram_val(rd_addr[1]);
  end

  typedef struct {int num; int duty; int poke; bit b2b; bit tight;} vec_t;

  int          n_chk = 0, n_err = 0;
  int          duty = 100;
  bit          tight = 1'b0;
  bit          mb[2], ed[2], pv[2], pr[2], plast[2];
  int          issued[2], popped[2], num_l[2], rel[2], fdone[2];
  logic [31:0] pdata[2];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int d = 0; d < 2; d++) begin
      mb[d] = 0; ed[d] = 0; pv[d] = 0; pr[d] = 0;
      issued[d] = 0; popped[d] = 0; rel[d] = 0;
    end
  endtask

  task automatic rst_check();
    for (int d = 0; d < 2; d++) begin
      chk("rst_ctl", {19'b0, rd_en[d], out_valid[d], out_last[d], busy[d], done[d], rd_addr[d]}, 32'h0);
      chk("rst_data", out_data[d], 32'h0);
    end
  endtask

  task automatic tick(input bit st);
    bit pop, acc, hs_last, ok_credit, inr;
    @(negedge clk);
    start = st;
    out_ready = ($urandom_range(99) < duty);
    #1;
    for (int d = 0; d < 2; d++) begin
      pop = out_valid[d] && out_ready;
      chk("busy", busy[d], mb[d]);
      chk("done", done[d], ed[d]);
      if (rd_en[d]) begin
        ok_credit = (issued[d] - popped[d] - int'(pop)) < 2;
        inr = mb[d] && issued[d] <= num_l[d];
        chk("rd_addr", {22'b0, ok_credit, inr, rd_addr[d]}, {22'b0, 2'b11, map_addr(d, issued[d])});
      end
      if (tight && mb[d]) begin
        chk("rd_en_timing", rd_en[d], rel[d] >= 1 && rel[d] <= num_l[d] + 1);
        chk("valid_timing", out_valid[d], rel[d] >= 3 && rel[d] <= num_l[d] + 3);
      end
      if (pv[d] && !pr[d]) begin
        chk("hold_data", out_data[d], pdata[d]);
        chk("hold_flags", {out_valid[d], out_last[d]}, {1'b1, plast[d]});
      end
      if (pop) begin
        inr = mb[d] && popped[d] <= num_l[d];
        chk("out_data", out_data[d], ram_val(map_addr(d, popped[d])));
        chk("out_last", {inr, out_last[d]}, {1'b1, popped[d] == num_l[d]});
      end
      pv[d] = out_valid[d]; pr[d] = out_ready; pdata[d] = out_data[d]; plast[d] = out_last[d];
      acc = st && !mb[d];
      hs_last = pop && mb[d] && popped[d] == num_l[d];
      issued[d] += int'(rd_en[d]);
      popped[d] += int'(pop);
      ed[d] = hs_last;
      if (hs_last) begin
        mb[d] = 0;
        fdone[d]++;
      end
      rel[d]++;
      if (acc) begin
        mb[d] = 1; num_l[d] = int'(num_m1); issued[d] = 0; popped[d] = 0; rel[d] = 1;
      end
    end
  endtask

  task automatic run_vec(input vec_t v);
    int t0, t1, cnt;
    bit st;
    duty = v.duty; tight = v.tight; num_m1 = 8'(v.num);
    t0 = fdone[0] + (v.b2b ? 2 : 1);
    t1 = fdone[1] + (v.b2b ? 2 : 1);
    tick(1'b1);
    cnt = 0;
    while ((fdone[0] < t0 || fdone[1] < t1) && cnt < 3000) begin
      st = (v.poke >= 0 && rel[0] == v.poke) || (v.b2b && ed[0] && fdone[0] == t0 - 1);
      tick(st);
      cnt++;
    end
    chk("frames_nat", fdone[0], t0);
    chk("frames_rev", fdone[1], t1);
    chk("count_nat", popped[0], v.num + 1);
    chk("count_rev", popped[1], v.num + 1);
    repeat (3) tick(1'b0);
  endtask

  vec_t vt[8];

  initial begin
    vt = '{'{7, 100, -1, 1'b0, 1'b1},
           '{255, 100, -1, 1'b0, 1'b1},
           '{15, 30, -1, 1'b0, 1'b0},
           '{0, 100, -1, 1'b0, 1'b1},
           '{0, 30, -1, 1'b0, 1'b0},
           '{10, 100, 5, 1'b0, 1'b1},
           '{3, 100, -1, 1'b1, 1'b1},
           '{31, 60, -1, 1'b0, 1'b0}};
    model_reset();
    fdone[0] = 0; fdone[1] = 0; num_l[0] = 0; num_l[1] = 0;
    repeat (2) @(negedge clk);
    #1 rst_check();
    @(negedge clk) rst_n = 1'b1;
    for (int k = 0; k < 8; k++) run_vec(vt[k]);

    // Abort a long frame with reset and confirm nothing resumes afterwards.
    duty = 100; tight = 1'b0; num_m1 = 8'd255;
    tick(1'b1);
    repeat (20) tick(1'b0);
    @(negedge clk);
    rst_n = 1'b0;
    #1 rst_check();
    model_reset();
    @(negedge clk) rst_n = 1'b1;
    repeat (8) tick(1'b0);
    for (int d = 0; d < 2; d++) chk("post_rst_idle", {rd_en[d], out_valid[d], busy[d]}, 3'b000);
    run_vec(vt[0]);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule
